// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, fetch FSM states and reset vector for the MIPS core
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      DELIVER = 2'd2,
      HALT    = 2'd3
   } fetch_state_t;

   // Instruction addresses are always word aligned; the low two bits are dropped.
   function automatic logic [ADDR_W-1:0] wordAlign(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// rtl/instr_fetch_pc_reg.sv - program counter with sync reset, redirect load and step increment
module pc_reg
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int                PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] loadPc,
   input  logic              advance,
   output logic [ADDR_W-1:0] pc
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   // Load wins over advance; the add wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= loadPc;
      end else if (advance) begin
         pc <= pc + STEP;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit with redirect handling
// Optional misaligned-redirect trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int                PC_STEP  = 4
) (
   input  logic               clk,
   input  logic               reset,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_gnt,
   input  logic               mem_rvalid,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               misalign
);

   fetch_state_t      state;
   fetch_state_t      nextState;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] reqPc;
   logic [ADDR_W-1:0] targetPc;
   logic              discard;
   logic              discardNext;
   logic              pcLoad;
   logic              pcAdvance;
   logic              capture;
   logic              dropValid;
   logic              grant;
   logic              trapHit;

   assign targetPc = wordAlign(redirect_pc);
   assign mem_addr = pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign trapHit = redirect && (redirect_pc[1:0] != 2'b00) && (state != HALT);
`else
   assign trapHit = 1'b0;
`endif

   pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk     (clk),
      .reset   (reset),
      .load    (pcLoad),
      .loadPc  (targetPc),
      .advance (pcAdvance),
      .pc      (pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         FETCH: begin
            if (trapHit) begin
               nextState = HALT;
            end else if (!redirect && mem_gnt) begin
               nextState = WAIT;
            end
         end
         WAIT: begin
            if (trapHit) begin
               nextState = HALT;
            end else if (redirect) begin
               nextState = mem_rvalid ? FETCH : WAIT;
            end else if (mem_rvalid) begin
               nextState = discard ? FETCH : DELIVER;
            end
         end
         DELIVER: begin
            if (trapHit) begin
               nextState = HALT;
            end else if (redirect || instr_ready) begin
               nextState = FETCH;
            end
         end
         HALT:    nextState = HALT;
         default: nextState = FETCH;
      endcase
   end

   always_comb begin
      mem_req     = 1'b0;
      pcLoad      = 1'b0;
      pcAdvance   = 1'b0;
      capture     = 1'b0;
      dropValid   = 1'b0;
      grant       = 1'b0;
      discardNext = discard;
      case (state)
         FETCH: begin
            mem_req = !redirect;
            pcLoad  = redirect && !trapHit;
            grant   = !redirect && mem_gnt;
         end
         WAIT: begin
            if (redirect) begin
               // A response arriving with the redirect is the stale one; nothing left to drop.
               pcLoad      = !trapHit;
               discardNext = !trapHit && !mem_rvalid;
            end else if (mem_rvalid) begin
               if (discard) begin
                  discardNext = 1'b0;
               end else begin
                  capture   = 1'b1;
                  pcAdvance = 1'b1;
               end
            end
         end
         DELIVER: begin
            if (redirect) begin
               dropValid = 1'b1;
               pcLoad    = !trapHit;
            end else if (instr_ready) begin
               dropValid = 1'b1;
            end
         end
         default: begin
         end
      endcase
      if (trapHit) begin
         dropValid   = 1'b1;
         discardNext = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         discard     <= 1'b0;
         reqPc       <= '0;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
      end else begin
         discard <= discardNext;
         if (grant) begin
            reqPc <= pc;
         end
         if (capture) begin
            instr       <= mem_rdata;
            instr_pc    <= reqPc;
            instr_valid <= 1'b1;
         end else if (dropValid) begin
            instr_valid <= 1'b0;
         end
      end
   end

`ifdef IFETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         misalign <= 1'b0;
      end else if (trapHit) begin
         misalign <= 1'b1;
      end
   end
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - table-driven cycle checks for instr_fetch plus reset and misalign sequences
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memGnt;
   logic        memRvalid;
   logic [31:0] memRdata;
   logic        instrValid;
   logic [31:0] instr;
   logic [31:0] instrPc;
   logic        instrReady;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        misalign;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (memReq),
      .mem_addr    (memAddr),
      .mem_gnt     (memGnt),
      .mem_rvalid  (memRvalid),
      .mem_rdata   (memRdata),
      .instr_valid (instrValid),
      .instr       (instr),
      .instr_pc    (instrPc),
      .instr_ready (instrReady),
      .redirect    (redirect),
      .redirect_pc (redirectPc),
      .misalign    (misalign)
   );

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        eReq;
      logic [31:0] eAddr;
      logic        eVal;
      logic [31:0] eInstr;
      logic [31:0] ePc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic redir, logic [31:0] rpc, logic gnt, logic rv,
                               logic [31:0] rdata, logic rdy, logic eReq, logic [31:0] eAddr,
                               logic eVal, logic [31:0] eInstr, logic [31:0] ePc);
      vec_t v;
      v.rst = rst; v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
      v.rdy = rdy; v.eReq = eReq; v.eAddr = eAddr; v.eVal = eVal; v.eInstr = eInstr; v.ePc = ePc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      redirect   = 1'b0;
      redirectPc = '0;
      memGnt     = 1'b0;
      memRvalid  = 1'b0;
      memRdata   = '0;
      instrReady = 1'b0;
   endtask

   initial begin
      // rst redir rpc  gnt rv rdata  rdy | eReq eAddr eVal eInstr ePc
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 1,0,            0,0,0));
      vecs.push_back(mk(0,0,0,            1,1,32'h2408_0001,1, 0,0,           0,0,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 0,0,            1,32'h2408_0001,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 1,32'h4,        0,0,0));
      vecs.push_back(mk(0,0,0,            1,1,32'h2409_0002,1, 0,0,           0,0,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 0,0,            1,32'h2409_0002,32'h4));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 1,32'h8,        0,0,0));
      vecs.push_back(mk(0,0,0,            1,1,32'h012A_5820,1, 0,0,           0,0,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 0,0,            1,32'h012A_5820,32'h8));
      vecs.push_back(mk(1,0,0,            0,0,0,           0, 0,0,            0,0,0));
      vecs.push_back(mk(0,0,0,            0,1,32'hDEAD_BEEF,1, 1,0,           0,0,0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0,0,0,         0,0,0,           1, 1,0,            0,0,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 1,0,            0,0,0));
      vecs.push_back(mk(0,0,0,            0,0,0,           1, 0,0,            0,0,0));
      vecs.push_back(mk(0,0,0,            0,1,32'h8C82_0010,0, 0,0,           0,0,0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0,0,0,         1,0,0,           0, 0,0,            1,32'h8C82_0010,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 0,0,            1,32'h8C82_0010,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 1,32'h4,        0,0,0));
      vecs.push_back(mk(0,1,32'h100,      1,0,0,           1, 0,0,            0,0,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 0,0,            0,0,0));
      vecs.push_back(mk(0,0,0,            1,1,32'hBAD0_0001,1, 0,0,           0,0,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 1,32'h100,      0,0,0));
      vecs.push_back(mk(0,0,0,            1,1,32'h1000_FFFF,1, 0,0,           0,0,0));
      vecs.push_back(mk(0,1,32'h40,       1,0,0,           1, 0,0,            1,32'h1000_FFFF,32'h100));
      vecs.push_back(mk(0,0,0,            0,0,0,           1, 1,32'h40,       0,0,0));
      vecs.push_back(mk(0,1,32'hFFFF_FFFC,1,0,0,           1, 0,0,            0,0,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 1,32'hFFFF_FFFC,0,0,0));
      vecs.push_back(mk(0,0,0,            1,1,32'h0800_0010,1, 0,0,           0,0,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 0,0,            1,32'h0800_0010,32'hFFFF_FFFC));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 1,32'h0,        0,0,0));
      vecs.push_back(mk(0,1,32'h200,      0,1,32'hBAD0_0002,1, 0,0,           0,0,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 1,32'h200,      0,0,0));
      vecs.push_back(mk(0,0,0,            1,1,32'h03E0_0008,1, 0,0,           0,0,0));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 0,0,            1,32'h03E0_0008,32'h200));
      vecs.push_back(mk(0,0,0,            1,0,0,           1, 1,32'h204,      0,0,0));

      idleInputs();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset instr_valid", 32'(instrValid), 32'd0);
      check("reset instr", instr, 32'd0);
      check("reset instr_pc", instrPc, 32'd0);
      check("reset misalign", 32'(misalign), 32'd0);
      check("reset mem_req", 32'(memReq), 32'd1);
      check("reset mem_addr", memAddr, 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset      = vecs[i].rst;
         redirect   = vecs[i].redir;
         redirectPc = vecs[i].rpc;
         memGnt     = vecs[i].gnt;
         memRvalid  = vecs[i].rv;
         memRdata   = vecs[i].rdata;
         instrReady = vecs[i].rdy;
         #1;
         if (!vecs[i].rst) begin
            check($sformatf("row%0d mem_req", i), 32'(memReq), 32'(vecs[i].eReq));
            if (vecs[i].eReq)
               check($sformatf("row%0d mem_addr", i), memAddr, vecs[i].eAddr);
            check($sformatf("row%0d instr_valid", i), 32'(instrValid), 32'(vecs[i].eVal));
            if (vecs[i].eVal) begin
               check($sformatf("row%0d instr", i), instr, vecs[i].eInstr);
               check($sformatf("row%0d instr_pc", i), instrPc, vecs[i].ePc);
            end
            check($sformatf("row%0d misalign", i), 32'(misalign), 32'd0);
         end
      end

      // Reset while a request is outstanding; the late response lands in FETCH.
      @(negedge clk);
      idleInputs();
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      memRvalid = 1'b1;
      memRdata  = 32'hBAD0_0003;
      #1;
      check("late rvalid mem_req", 32'(memReq), 32'd1);
      check("late rvalid mem_addr", memAddr, 32'd0);
      @(negedge clk);
      memRvalid = 1'b0;
      #1;
      check("late rvalid ignored", 32'(instrValid), 32'd0);
      check("late rvalid still fetch", 32'(memReq), 32'd1);

      // Misaligned redirect from FETCH.
      @(negedge clk);
      redirect   = 1'b1;
      redirectPc = 32'h102;
      #1;
      check("misalign redirect req", 32'(memReq), 32'd0);
      @(negedge clk);
      redirect = 1'b0;
      #1;
`ifdef IFETCH_MISALIGN_TRAP_EN
      check("trap misalign set", 32'(misalign), 32'd1);
      check("trap req low", 32'(memReq), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         memGnt     = 1'b1;
         redirect   = i[0];
         redirectPc = 32'h40;
         #1;
         check($sformatf("halt%0d mem_req", i), 32'(memReq), 32'd0);
         check($sformatf("halt%0d instr_valid", i), 32'(instrValid), 32'd0);
         check($sformatf("halt%0d misalign", i), 32'(misalign), 32'd1);
      end
      @(negedge clk);
      idleInputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("halt exit misalign", 32'(misalign), 32'd0);
      check("halt exit mem_req", 32'(memReq), 32'd1);
      check("halt exit mem_addr", memAddr, 32'd0);
`else
      check("aligned misalign", 32'(misalign), 32'd0);
      check("aligned req", 32'(memReq), 32'd1);
      check("aligned addr", memAddr, 32'h100);
      memGnt = 1'b1;
      @(negedge clk);
      memGnt    = 1'b0;
      memRvalid = 1'b1;
      memRdata  = 32'h2402_000A;
      @(negedge clk);
      memRvalid = 1'b0;
      #1;
      check("aligned instr_valid", 32'(instrValid), 32'd1);
      check("aligned instr", instr, 32'h2402_000A);
      check("aligned instr_pc", instrPc, 32'h100);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
